// File: rtl/uart_cmd_bridge_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_cmd_pkg
// Brief    : Shared types and frame byte codes for the UART command bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_SEND = 3'd4
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

  // A command byte opens a frame only if it is one of the two known opcodes.
  function automatic logic is_valid_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_bridge_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_cmd_bridge_if
// Brief    : FIFO-side and register-bus signals of the UART command bridge.
//            'master' is the bridge view, 'slave' the FIFO/peripheral view.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_cmd_bridge_if;

  // Receive FIFO (first-word-fall-through)
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  // Transmit FIFO
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;

  // Register bus
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport master (
    input  rx_empty, r_data, tx_full, bus_ack, bus_rdata,
    output rd_uart, w_data, wr_uart, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output rx_empty, r_data, tx_full, bus_ack, bus_rdata,
    input  rd_uart, w_data, wr_uart, bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_cmd_bridge
// Brief    : Pops W/R command frames from the UART receive FIFO, runs one
//            register-bus access per frame and pushes a single response byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  uart_cmd_bridge_if.master bif
);

  // Counter value seen during the last permitted bus cycle.
  localparam logic [15:0] c_TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e      r_state;
  state_e      w_next_state;
  logic        w_pop;
  logic        w_push;
  logic        w_tmo_hit;

  logic        r_is_wr;
  logic [7:0]  r_rsp;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [7:0]  r_bus_addr;
  logic [7:0]  r_bus_wdata;
  logic [15:0] r_tmo_cnt;

  assign w_tmo_hit = (r_state == ST_BUS) && (r_tmo_cnt == c_TMO_LAST);

  // State register; reset drops any partially received frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode and the combinational FIFO pop/push strobes.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bif.rx_empty) begin
          w_pop        = 1'b1;
          w_next_state = is_valid_cmd(bif.r_data) ? ST_ADDR : ST_SEND;
        end
      end
      ST_ADDR: begin
        if (!bif.rx_empty) begin
          w_pop        = 1'b1;
          w_next_state = r_is_wr ? ST_DATA : ST_BUS;
        end
      end
      ST_DATA: begin
        if (!bif.rx_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (bif.bus_ack || w_tmo_hit) w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (!bif.tx_full) begin
          w_push       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame capture, bus request registers and the response byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_wr     <= 1'b0;
      r_rsp       <= 8'h00;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 8'h00;
      r_bus_wdata <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_is_wr <= (bif.r_data == CMD_WR);
            if (!is_valid_cmd(bif.r_data)) r_rsp <= RSP_ERR;
          end
        end
        ST_ADDR: begin
          if (w_pop) begin
            r_bus_addr <= bif.r_data;
            // A read has no data byte, so the request starts right away.
            if (!r_is_wr) begin
              r_bus_req <= 1'b1;
              r_bus_we  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_pop) begin
            r_bus_wdata <= bif.r_data;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b1;
          end
        end
        ST_BUS: begin
          if (bif.bus_ack) begin
            r_bus_req <= 1'b0;
            r_rsp     <= r_bus_we ? RSP_OK : bif.bus_rdata;
          end else if (w_tmo_hit) begin
            r_bus_req <= 1'b0;
            r_rsp     <= RSP_TMO;
          end
        end
        default: ;
      endcase
    end
  end

  // Ack timeout counter: held at zero outside BUS, counts un-acked BUS cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_tmo_cnt <= 16'h0000;
    else if (r_state != ST_BUS)  r_tmo_cnt <= 16'h0000;
    else if (!bif.bus_ack)       r_tmo_cnt <= r_tmo_cnt + 16'h0001;
  end

  // Pop is masked during reset so no byte is consumed while the frame is dropped.
  assign bif.rd_uart   = w_pop && !reset;
  assign bif.wr_uart   = w_push;
  assign bif.w_data    = r_rsp;
  assign bif.bus_req   = r_bus_req;
  assign bif.bus_we    = r_bus_we;
  assign bif.bus_addr  = r_bus_addr;
  assign bif.bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_uart_cmd_bridge
// Brief    : Self-checking bench for uart_cmd_bridge with a queue-based FIFO
//            model, a register-file bus responder and a frame-level reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_cmd_bridge;

  typedef struct {int cyc; logic [7:0] data;} ev_t;
  typedef struct {int cyc; logic we; logic [7:0] addr; logic [7:0] wdata;} txn_t;
  typedef struct {int start; int len;} req_t;

  logic clk = 1'b0;
  logic reset;
  uart_cmd_bridge_if bif();

  uart_cmd_bridge #(.ACK_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment state
  logic [7:0] rx_q[$];
  int         ack_plan[$];
  logic [7:0] tb_mem[256];
  ev_t        pop_log[$];
  ev_t        tx_log[$];
  txn_t       txn_log[$];
  req_t       req_log[$];
  bit         rand_mode = 1'b0;
  bit         tx_hold   = 1'b0;
  bit         rx_stall;
  int         cyc = 0;
  int         req_cycles = 0;
  int         cur_delay = 1;
  int         req_start = 0;
  logic       req_we;
  logic [7:0] req_addr, req_wdata;
  int         stab_err = 0;
  int         bad_pop = 0;
  int         bad_push = 0;

  // One clock cycle: drive inputs after the falling edge, then observe what
  // the DUT will do at the next rising edge.
  task automatic tick();
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    rx_stall = rand_mode && ($urandom_range(0, 4) == 0);
    bif.rx_empty  = (rx_q.size() == 0) || rx_stall;
    bif.r_data    = bif.rx_empty ? 8'($urandom) : rx_q[0];
    bif.tx_full   = tx_hold || (rand_mode && ($urandom_range(0, 3) == 0));
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 8'($urandom);
    if (bif.bus_req) begin
      if (req_cycles == 0) begin
        cur_delay = 1;
        if (ack_plan.size() > 0) cur_delay = ack_plan.pop_front();
        req_start = cyc;
        req_we    = bif.bus_we;
        req_addr  = bif.bus_addr;
        req_wdata = bif.bus_wdata;
      end else if (bif.bus_we !== req_we || bif.bus_addr !== req_addr ||
                   bif.bus_wdata !== req_wdata) begin
        stab_err++;
      end
      req_cycles++;
      if (cur_delay >= 0 && req_cycles == cur_delay + 1) begin
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = tb_mem[bif.bus_addr];
      end
    end else begin
      if (req_cycles != 0) begin
        req_log.push_back('{req_start, req_cycles});
        req_cycles = 0;
      end
      if (rand_mode && $urandom_range(0, 7) == 0) bif.bus_ack = 1'b1;
    end
    #1;
    if (bif.rd_uart) begin
      if (bif.rx_empty) bad_pop++;
      else begin
        b = rx_q.pop_front();
        pop_log.push_back('{cyc, b});
      end
    end
    if (bif.wr_uart) begin
      if (bif.tx_full) bad_push++;
      tx_log.push_back('{cyc, bif.w_data});
    end
    if (bif.bus_req && bif.bus_ack) begin
      txn_log.push_back('{cyc, bif.bus_we, bif.bus_addr, bif.bus_wdata});
      if (bif.bus_we) tb_mem[bif.bus_addr] = bif.bus_wdata;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin tick(); k++; end
    ok = (tx_log.size() >= n);
  endtask

  task automatic clear_logs();
    pop_log.delete(); tx_log.delete(); txn_log.delete(); req_log.delete();
    ack_plan.delete(); stab_err = 0; bad_pop = 0; bad_push = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.rx_empty = 1'b0; bif.r_data = 8'h57; bif.tx_full = 1'b0;
    bif.bus_ack = 1'b1; bif.bus_rdata = 8'hFF;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (bif.rd_uart !== 1'b0) begin n_fail++; $display("FAIL reset_rd_uart: got %b want 0", bif.rd_uart); end
    n_checks++; if (bif.wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset_wr_uart: got %b want 0", bif.wr_uart); end
    n_checks++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bif.bus_req); end
    n_checks++; if (bif.bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", bif.bus_we); end
    n_checks++; if (bif.w_data !== 8'h00) begin n_fail++; $display("FAIL reset_w_data: got %h want 00", bif.w_data); end
    n_checks++; if (bif.bus_addr !== 8'h00) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 00", bif.bus_addr); end
    n_checks++; if (bif.bus_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_bus_wdata: got %h want 00", bif.bus_wdata); end
    bif.rx_empty = 1'b1; bif.bus_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run(3);
    n_checks++; if (tx_log.size() + txn_log.size() + pop_log.size() !== 0) begin n_fail++; $display("FAIL reset_idle_activity: got %0d events want 0", tx_log.size() + txn_log.size() + pop_log.size()); end
  endtask

  task automatic test_write();
    bit ok;
    clear_logs();
    ack_plan.push_back(2);
    rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5);
    wait_tx(1, 100, ok);
    run(6);
    n_checks++; if (!ok || tx_log.size() != 1) begin n_fail++; $display("FAIL wr_push_count: got %0d want 1", tx_log.size()); end
    n_checks++; if (txn_log.size() != 1) begin n_fail++; $display("FAIL wr_txn_count: got %0d want 1", txn_log.size()); end
    if (tx_log.size() >= 1 && txn_log.size() >= 1 && req_log.size() >= 1 && pop_log.size() == 3) begin
      n_checks++; if (txn_log[0].we !== 1'b1 || txn_log[0].addr !== 8'h10 || txn_log[0].wdata !== 8'hA5) begin
        n_fail++; $display("FAIL wr_txn: got we=%b addr=%h data=%h want we=1 addr=10 data=a5", txn_log[0].we, txn_log[0].addr, txn_log[0].wdata); end
      n_checks++; if (tx_log[0].data !== 8'h4B) begin n_fail++; $display("FAIL wr_rsp: got %h want 4b", tx_log[0].data); end
      n_checks++; if (req_log[0].start - pop_log[2].cyc != 1) begin n_fail++; $display("FAIL wr_req_latency: got %0d want 1", req_log[0].start - pop_log[2].cyc); end
      n_checks++; if (req_log[0].len != 3) begin n_fail++; $display("FAIL wr_req_len: got %0d want 3", req_log[0].len); end
      n_checks++; if (tx_log[0].cyc - txn_log[0].cyc != 1) begin n_fail++; $display("FAIL wr_rsp_latency: got %0d want 1", tx_log[0].cyc - txn_log[0].cyc); end
    end else begin
      n_checks++; n_fail++; $display("FAIL wr_logs: tx=%0d txn=%0d req=%0d pop=%0d want 1/1/1/3", tx_log.size(), txn_log.size(), req_log.size(), pop_log.size());
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_logs();
    tb_mem[8'h20] = 8'h3C;
    ack_plan.push_back($urandom_range(0, 5));
    rx_q.push_back(8'h52); rx_q.push_back(8'h20);
    wait_tx(1, 100, ok);
    run(4);
    n_checks++; if (!ok || tx_log.size() != 1 || txn_log.size() != 1) begin
      n_fail++; $display("FAIL rd_counts: got push=%0d txn=%0d want 1/1", tx_log.size(), txn_log.size());
    end else begin
      n_checks++; if (txn_log[0].we !== 1'b0 || txn_log[0].addr !== 8'h20) begin
        n_fail++; $display("FAIL rd_txn: got we=%b addr=%h want we=0 addr=20", txn_log[0].we, txn_log[0].addr); end
      n_checks++; if (tx_log[0].data !== 8'h3C) begin n_fail++; $display("FAIL rd_rsp: got %h want 3c", tx_log[0].data); end
    end
  endtask

  task automatic test_invalid();
    bit ok;
    clear_logs();
    tb_mem[8'h05] = 8'hC7;
    ack_plan.push_back(1);
    rx_q.push_back(8'h41); rx_q.push_back(8'h52); rx_q.push_back(8'h05);
    wait_tx(2, 100, ok);
    run(4);
    n_checks++; if (!ok || tx_log.size() != 2 || req_log.size() != 1 || pop_log.size() != 3) begin
      n_fail++; $display("FAIL inv_counts: got push=%0d req=%0d pop=%0d want 2/1/3", tx_log.size(), req_log.size(), pop_log.size());
    end else begin
      n_checks++; if (tx_log[0].data !== 8'h45) begin n_fail++; $display("FAIL inv_rsp: got %h want 45", tx_log[0].data); end
      n_checks++; if (tx_log[0].cyc - pop_log[0].cyc != 1) begin n_fail++; $display("FAIL inv_latency: got %0d want 1", tx_log[0].cyc - pop_log[0].cyc); end
      n_checks++; if (req_log[0].start <= pop_log[2].cyc) begin n_fail++; $display("FAIL inv_no_req: req at %0d before read addr pop %0d", req_log[0].start, pop_log[2].cyc); end
      n_checks++; if (tx_log[1].data !== 8'hC7) begin n_fail++; $display("FAIL inv_next_read: got %h want c7", tx_log[1].data); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    ack_plan.push_back(-1);
    rx_q.push_back(8'h52); rx_q.push_back(8'h30);
    wait_tx(1, 100, ok);
    run(3);
    n_checks++; if (!ok || tx_log.size() != 1 || req_log.size() != 1) begin
      n_fail++; $display("FAIL tmo_counts: got push=%0d req=%0d want 1/1", tx_log.size(), req_log.size());
    end else begin
      n_checks++; if (req_log[0].len != 8) begin n_fail++; $display("FAIL tmo_req_len: got %0d want 8", req_log[0].len); end
      n_checks++; if (tx_log[0].data !== 8'h54) begin n_fail++; $display("FAIL tmo_rsp: got %h want 54", tx_log[0].data); end
    end
    // Ack arriving on the last permitted cycle must win over the timeout.
    clear_logs();
    tb_mem[8'h31] = 8'h9E;
    ack_plan.push_back(7);
    rx_q.push_back(8'h52); rx_q.push_back(8'h31);
    wait_tx(1, 100, ok);
    run(3);
    n_checks++; if (!ok || tx_log.size() != 1 || req_log.size() != 1) begin
      n_fail++; $display("FAIL tmo_edge_counts: got push=%0d req=%0d want 1/1", tx_log.size(), req_log.size());
    end else begin
      n_checks++; if (req_log[0].len != 8) begin n_fail++; $display("FAIL tmo_edge_len: got %0d want 8", req_log[0].len); end
      n_checks++; if (tx_log[0].data !== 8'h9E) begin n_fail++; $display("FAIL tmo_edge_rsp: got %h want 9e", tx_log[0].data); end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int k, pops0;
    clear_logs();
    tb_mem[8'h44] = 8'h77;
    ack_plan.push_back(1); ack_plan.push_back(1);
    tx_hold = 1'b1;
    rx_q.push_back(8'h57); rx_q.push_back(8'h40); rx_q.push_back(8'h12);
    rx_q.push_back(8'h52); rx_q.push_back(8'h44);
    k = 0;
    while (txn_log.size() < 1 && k < 100) begin tick(); k++; end
    pops0 = pop_log.size();
    run(50);
    n_checks++; if (txn_log.size() != 1 || pop_log.size() != pops0 || tx_log.size() != 0) begin
      n_fail++; $display("FAIL bp_hold: got txn=%0d pops=%0d->%0d push=%0d want 1, no pops, 0", txn_log.size(), pops0, pop_log.size(), tx_log.size()); end
    tx_hold = 1'b0;
    wait_tx(2, 100, ok);
    run(3);
    n_checks++; if (!ok || tx_log.size() != 2 || pop_log.size() != 5) begin
      n_fail++; $display("FAIL bp_counts: got push=%0d pops=%0d want 2/5", tx_log.size(), pop_log.size());
    end else begin
      n_checks++; if (tx_log[0].data !== 8'h4B || tx_log[1].data !== 8'h77) begin
        n_fail++; $display("FAIL bp_rsp: got %h,%h want 4b,77", tx_log[0].data, tx_log[1].data); end
      n_checks++; if (pop_log[3].cyc <= tx_log[0].cyc) begin
        n_fail++; $display("FAIL bp_order: got pop at %0d push at %0d want pop after push", pop_log[3].cyc, tx_log[0].cyc); end
    end
    n_checks++; if (bad_push != 0) begin n_fail++; $display("FAIL bp_push_while_full: got %0d want 0", bad_push); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int k;
    clear_logs();
    tb_mem[8'h11] = 8'h5D;
    rx_q.push_back(8'h57); rx_q.push_back(8'h10);
    k = 0;
    while (pop_log.size() < 2 && k < 50) begin tick(); k++; end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (bif.bus_addr !== 8'h00 || bif.bus_req !== 1'b0 || bif.bus_we !== 1'b0 ||
                    bif.w_data !== 8'h00 || bif.rd_uart !== 1'b0 || bif.wr_uart !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got addr=%h req=%b we=%b wdata=%h rd=%b wr=%b want all zero",
                         bif.bus_addr, bif.bus_req, bif.bus_we, bif.w_data, bif.rd_uart, bif.wr_uart); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    ack_plan.push_back(2);
    rx_q.push_back(8'h52); rx_q.push_back(8'h11);
    wait_tx(1, 100, ok);
    run(3);
    n_checks++; if (!ok || tx_log.size() != 1 || txn_log.size() != 1) begin
      n_fail++; $display("FAIL mid_counts: got push=%0d txn=%0d want 1/1", tx_log.size(), txn_log.size());
    end else begin
      n_checks++; if (txn_log[0].we !== 1'b0 || txn_log[0].addr !== 8'h11) begin
        n_fail++; $display("FAIL mid_txn: got we=%b addr=%h want we=0 addr=11", txn_log[0].we, txn_log[0].addr); end
      n_checks++; if (tx_log[0].data !== 8'h5D) begin n_fail++; $display("FAIL mid_rsp: got %h want 5d", tx_log[0].data); end
    end
  endtask

  // Random frames with random ack delays, FIFO stalls, back-pressure and
  // stray acks, checked against a frame-level model of the register file.
  task automatic test_random();
    logic [7:0] ref_mem[256];
    logic [7:0] exp_rsp[$];
    txn_t       exp_txn[$];
    logic [7:0] c, a, d;
    int         t, dl;
    bit         ok;
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    for (int f = 0; f < 40; f++) begin
      t = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if (t >= 8) begin
        do c = 8'($urandom); while (c == 8'h57 || c == 8'h52);
        rx_q.push_back(c);
        exp_rsp.push_back(8'h45);
      end else begin
        dl = $urandom_range(0, 9);
        ack_plan.push_back(dl);
        rx_q.push_back(t < 4 ? 8'h57 : 8'h52);
        rx_q.push_back(a);
        if (t < 4) rx_q.push_back(d);
        if (dl > 7) exp_rsp.push_back(8'h54);
        else if (t < 4) begin
          exp_txn.push_back('{0, 1'b1, a, d});
          ref_mem[a] = d;
          exp_rsp.push_back(8'h4B);
        end else begin
          exp_txn.push_back('{0, 1'b0, a, 8'h00});
          exp_rsp.push_back(ref_mem[a]);
        end
      end
    end
    rand_mode = 1'b1;
    wait_tx(exp_rsp.size(), 5000, ok);
    rand_mode = 1'b0;
    run(5);
    n_checks++; if (!ok || tx_log.size() != exp_rsp.size()) begin
      n_fail++; $display("FAIL rnd_rsp_count: got %0d want %0d", tx_log.size(), exp_rsp.size()); end
    n_checks++; if (txn_log.size() != exp_txn.size()) begin
      n_fail++; $display("FAIL rnd_txn_count: got %0d want %0d", txn_log.size(), exp_txn.size()); end
    for (int i = 0; i < exp_rsp.size() && i < tx_log.size(); i++) begin
      n_checks++; if (tx_log[i].data !== exp_rsp[i]) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got %h want %h", i, tx_log[i].data, exp_rsp[i]); end
    end
    for (int i = 0; i < exp_txn.size() && i < txn_log.size(); i++) begin
      n_checks++; if (txn_log[i].we !== exp_txn[i].we || txn_log[i].addr !== exp_txn[i].addr ||
                      (exp_txn[i].we && txn_log[i].wdata !== exp_txn[i].wdata)) begin
        n_fail++; $display("FAIL rnd_txn[%0d]: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", i,
                           txn_log[i].we, txn_log[i].addr, txn_log[i].wdata, exp_txn[i].we, exp_txn[i].addr, exp_txn[i].wdata); end
    end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL rnd_bus_stable: got %0d changes want 0", stab_err); end
    n_checks++; if (bad_pop != 0 || bad_push != 0) begin
      n_fail++; $display("FAIL rnd_fifo_rules: got pop_when_empty=%0d push_when_full=%0d want 0/0", bad_pop, bad_push); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_invalid();
    test_timeout();
    test_back_pressure();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_bridge.md
# uart_cmd_bridge

Command bridge on the far side of the UART's FIFO interface. It pops command frames from the receive FIFO, executes byte reads and writes on a simple request/acknowledge register bus, and pushes one response byte per frame into the transmit FIFO. It sits between the `uart` block's `rd_uart/r_data/rx_empty` and `wr_uart/w_data/tx_full` ports and on-chip peripheral registers.

## Interface

**Parameters**

- `ACK_TIMEOUT`, default 255: bus cycles to wait for `bus_ack` before aborting. Legal range 1..65535.

**Ports**

- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: system clock.
  - `reset` in 1: asynchronous, active-high reset.
- Receive FIFO side:
  - `rx_empty` in 1: receive FIFO empty.
  - `r_data` in 8: receive FIFO head byte. First-word-fall-through, so it is valid while `rx_empty=0`.
  - `rd_uart` out 1: one-cycle pop of the receive FIFO head.
- Transmit FIFO side:
  - `tx_full` in 1: transmit FIFO full.
  - `w_data` out 8: response byte.
  - `wr_uart` out 1: one-cycle push of `w_data`.
- Register bus:
  - `bus_req` out 1: bus request.
  - `bus_we` out 1: 1 = write, 0 = read.
  - `bus_addr` out 8: register address.
  - `bus_wdata` out 8: write data.
  - `bus_ack` in 1: single-cycle completion strobe.
  - `bus_rdata` in 8: read data, valid on the `bus_ack` cycle.

## Operation

**Frames**

- Write frame: `0x57` ('W'), addr, data. Response `0x4B` ('K').
- Read frame: `0x52` ('R'), addr. Response is the byte read.
- Any other first byte: respond `0x45` ('E'), issue no bus request, and return to IDLE.
- Bus timeout: respond `0x54` ('T').

**FSM states**

- `IDLE`: on `!rx_empty`, pop and decode the command byte. 'W' or 'R' → `ADDR`; otherwise → `SEND` with 'E'.
- `ADDR`: on `!rx_empty`, pop and latch the address. Go to `DATA` for a write, or `BUS` for a read.
- `DATA`: on `!rx_empty`, pop and latch write data, then go to `BUS`.
- `BUS`: `bus_req=1` until `bus_ack` or timeout, then go to `SEND`.
- `SEND`: hold the response. When `!tx_full`, push it and return to `IDLE`.

**FIFO handshakes**

- `rd_uart = (state ∈ {IDLE, ADDR, DATA}) && !rx_empty`. This is combinational; the byte is captured on the same edge it is popped.
- `wr_uart = (state == SEND) && !tx_full`. This is combinational. `w_data` comes from the response register.
- No pops occur in `BUS` or `SEND`. Incoming bytes queue in the receive FIFO, so back-pressure from `tx_full` propagates to the receiver.

**Bus rules**

- `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` are registered and stay stable for the whole request.
- `bus_req` drops the cycle after `bus_ack` is sampled.
- The timeout counter (16-bit) clears on entry to `BUS` and increments each `BUS` cycle without ack. When it reaches `ACK_TIMEOUT`, the request aborts.
- If `bus_ack` arrives on the same cycle as the timeout, ack wins and the normal response is sent.
- `bus_ack` outside `BUS` is ignored.

## Timing

**Reset values** (also applied on reset mid-frame, immediately and asynchronously)

- State `IDLE`.
- `rd_uart`, `wr_uart`, `bus_req`, `bus_we` = 0.
- `w_data`, `bus_addr`, `bus_wdata` = 0x00.
- The timeout counter is 0.
- A partial frame is discarded; the next byte is decoded as a command.

**Latency**

- The byte pop rate is at most 1 per cycle.
- Last frame byte popped at edge N → `bus_req` high in cycle N+1.
- `bus_ack` sampled at the end of cycle M → `SEND` in cycle M+1. `wr_uart` is asserted in M+1 if `!tx_full`.
- Invalid command popped at edge N → `wr_uart` in cycle N+1 if `!tx_full`.
- Timeout: `bus_req` is high for exactly `ACK_TIMEOUT` cycles, then `SEND` with 'T'.

## Structure

- Package `uart_cmd_pkg` holds:
  - the state enum;
  - localparams `CMD_WR=8'h57`, `CMD_RD=8'h52`, `RSP_OK=8'h4B`, `RSP_ERR=8'h45`, `RSP_TMO=8'h54`.
- Single module with no sub-module. The timeout counter is inline.
- Top-level integration wires the bridge directly to the `uart` FIFO ports.

## Test plan

- **Write frame:** push 0x57, 0x10, 0xA5; ack 2 cycles after `bus_req` rises. Required: one write with `bus_we=1`, addr 0x10, data 0xA5; then exactly one push of 0x4B.
- **Read frame:** push 0x52, 0x20; return `bus_rdata=0x3C` with ack. Required: `bus_we=0`, addr 0x20; then one push of 0x3C.
- **Invalid command:** push 0x41. Required: `bus_req` never asserts; push of 0x45 one cycle after the pop; the next 'R' frame is processed normally.
- **Bus timeout:** with `ACK_TIMEOUT=8`, send 'R', 0x30 and never ack. Required: `bus_req` high for exactly 8 cycles, then push of 0x54. A second variant acks on the 8th cycle and requires the read data, not 'T'.
- **Transmit back-pressure:** hold `tx_full=1` for 50 cycles while a 'W' response is pending and a second frame waits in the receive FIFO. Required: `wr_uart`=0 and no pops during the hold; on release, one push of 0x4B, then the second frame proceeds.
- **Reset mid-frame:** send 0x57, 0x10, then pulse `reset`, then send 0x52, 0x11. Required: outputs return to reset values asynchronously, no write occurs, and the read of 0x11 completes normally.
